// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU sequencer: one-hot state bit positions,
// operation encodings and a one-hot legality helper.
package alu_ctrl_pkg;

  localparam int N_STATES = 11;

  localparam int S_IDLE        = 0;
  localparam int S_LOAD        = 1;
  localparam int S_EXEC        = 2;
  localparam int S_BOOTH_CHK   = 3;
  localparam int S_BOOTH_SHIFT = 4;
  localparam int S_DIV_SHIFT   = 5;
  localparam int S_DIV_SUB     = 6;
  localparam int S_DIV_FIX     = 7;
  localparam int S_OUT_HI      = 8;
  localparam int S_OUT_LO      = 9;
  localparam int S_DONE        = 10;

  typedef logic [N_STATES-1:0] state_vec_t;

  localparam state_vec_t STATE_IDLE = state_vec_t'(1);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input state_vec_t s);
    return (s != '0) && ((s & (s - state_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/alu_ctrl_state_reg.sv
// One-hot state register for the ALU sequencer; reset lands on IDLE only.
module alu_ctrl_state_reg
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  state_vec_t state_d,
  output state_vec_t state_q
);

  always_ff @(posedge clk) begin
    if (reset) state_q <= STATE_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/alu_control_unit.sv
// Sequencer for an add/sub/Booth-multiply/restoring-divide datapath.
// Strobes decode from the one-hot state; an illegal state idles all outputs.
module alu_control_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic                q0,
  input  logic                q_m1,
  input  logic                a_sign,
  input  logic                divisor_zero,
  output logic                clr_a,
  output logic                ld_a,
  output logic                ld_m,
  output logic                ld_q,
  output logic                add_en,
  output logic                sub_en,
  output logic                shift_en,
  output logic                shift_left,
  output logic                set_q0,
  output logic                out_hi,
  output logic                out_lo,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [N_STATES-1:0] state,
  output logic [CNT_W-1:0]    cnt
);

  state_vec_t       state_q;
  state_vec_t       state_nxt;
  wire  state_vec_t state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic             err_q, err_d;
  logic             valid;
  logic             last;

  assign state_d = state_nxt;

  alu_ctrl_state_reg u_state_reg (
    .clk     (clk),
    .reset   (reset),
    .state_d (state_d),
    .state_q (state_q)
  );

  assign state = state_q;
  assign cnt   = cnt_q;
  assign valid = !reset && is_onehot(state_q);
  assign last  = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt  = '0;
    cnt_d      = cnt_q;
    op_d       = op_q;
    err_d      = err_q;
    clr_a      = 1'b0;
    ld_a       = 1'b0;
    ld_m       = 1'b0;
    ld_q       = 1'b0;
    add_en     = 1'b0;
    sub_en     = 1'b0;
    shift_en   = 1'b0;
    shift_left = 1'b0;
    set_q0     = 1'b0;
    out_hi     = 1'b0;
    out_lo     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    if (!valid) begin
      state_nxt = STATE_IDLE;
    end else begin
      busy = !state_q[S_IDLE];
      case (1'b1)
        state_q[S_IDLE]: begin
          err_d = 1'b0;
          if (start) begin
            op_d              = op_e'(op);
            state_nxt[S_LOAD] = 1'b1;
          end else begin
            state_nxt[S_IDLE] = 1'b1;
          end
        end
        state_q[S_LOAD]: begin
          ld_m  = 1'b1;
          ld_q  = 1'b1;
          cnt_d = '0;
          if (op_q == OP_ADD || op_q == OP_SUB) ld_a = 1'b1;
          else                                  clr_a = 1'b1;
          err_d = (op_q == OP_DIV) && divisor_zero;
          if (op_q == OP_DIV && divisor_zero) state_nxt[S_DONE] = 1'b1;
          else if (op_q == OP_MUL)            state_nxt[S_BOOTH_CHK] = 1'b1;
          else if (op_q == OP_DIV)            state_nxt[S_DIV_SHIFT] = 1'b1;
          else                                state_nxt[S_EXEC] = 1'b1;
        end
        state_q[S_EXEC]: begin
          if (op_q == OP_SUB) sub_en = 1'b1;
          else                add_en = 1'b1;
          state_nxt[S_OUT_LO] = 1'b1;
        end
        state_q[S_BOOTH_CHK]: begin
          // 10 starts a run of ones (subtract M), 01 ends one (add M)
          case ({q0, q_m1})
            2'b10:   sub_en = 1'b1;
            2'b01:   add_en = 1'b1;
            default: ;
          endcase
          state_nxt[S_BOOTH_SHIFT] = 1'b1;
        end
        state_q[S_BOOTH_SHIFT]: begin
          shift_en = 1'b1;
          if (last) begin
            state_nxt[S_OUT_HI] = 1'b1;
          end else begin
            cnt_d                  = cnt_q + CNT_W'(1);
            state_nxt[S_BOOTH_CHK] = 1'b1;
          end
        end
        state_q[S_DIV_SHIFT]: begin
          shift_en   = 1'b1;
          shift_left = 1'b1;
          state_nxt[S_DIV_SUB] = 1'b1;
        end
        state_q[S_DIV_SUB]: begin
          sub_en = 1'b1;
          state_nxt[S_DIV_FIX] = 1'b1;
        end
        state_q[S_DIV_FIX]: begin
          if (a_sign) add_en = 1'b1;
          else        set_q0 = 1'b1;
          if (last) begin
            state_nxt[S_OUT_HI] = 1'b1;
          end else begin
            cnt_d                  = cnt_q + CNT_W'(1);
            state_nxt[S_DIV_SHIFT] = 1'b1;
          end
        end
        state_q[S_OUT_HI]: begin
          out_hi = 1'b1;
          state_nxt[S_OUT_LO] = 1'b1;
        end
        state_q[S_OUT_LO]: begin
          out_lo = 1'b1;
          state_nxt[S_DONE] = 1'b1;
        end
        state_q[S_DONE]: begin
          done  = 1'b1;
          error = err_q;
          state_nxt[S_IDLE] = 1'b1;
        end
        default: state_nxt = STATE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= OP_ADD;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: cycle-exact strobe and latency checks
// for every op, divide-by-zero, mid-op reset and illegal state recovery.
module tb_alu_control_unit;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, q0, q_m1, a_sign, divisor_zero;
  logic [1:0]  op;
  logic        clr_a, ld_a, ld_m, ld_q, add_en, sub_en, shift_en, shift_left;
  logic        set_q0, out_hi, out_lo, busy, done, error;
  logic [10:0] state;
  logic [2:0]  cnt;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0] bpat [4] = '{2'b10, 2'b01, 2'b11, 2'b00};

  wire [13:0] outs_w = {clr_a, ld_a, ld_m, ld_q, add_en, sub_en, shift_en,
                        shift_left, set_q0, out_hi, out_lo, busy, done, error};

  alu_control_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .q0(q0), .q_m1(q_m1),
    .a_sign(a_sign), .divisor_zero(divisor_zero), .clr_a(clr_a), .ld_a(ld_a),
    .ld_m(ld_m), .ld_q(ld_q), .add_en(add_en), .sub_en(sub_en),
    .shift_en(shift_en), .shift_left(shift_left), .set_q0(set_q0),
    .out_hi(out_hi), .out_lo(out_lo), .busy(busy), .done(done),
    .error(error), .state(state), .cnt(cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] st(input int b);
    return 11'(1) << b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start sampled at the next edge (edge 0); returns in cycle 1.
  task automatic begin_op(input logic [1:0] o);
    op    = o;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int j, ph, n_sh, n_left, n_bad, done_at;
    reset = 1'b1; start = 1'b0; op = 2'b00; q0 = 1'b0; q_m1 = 1'b0;
    a_sign = 1'b0; divisor_zero = 1'b0;
    repeat (2) cyc();
    #1;
    chk("rst_state", state, st(S_IDLE));
    chk("rst_cnt", cnt, 0);
    chk("rst_outs", outs_w, 0);
    start = 1'b1; op = 2'b10;
    cyc(); #1;
    chk("rst_over_start", state, st(S_IDLE));
    chk("rst_outs_start", outs_w, 0);
    reset = 1'b0; start = 1'b0;
    cyc();

    // add
    begin_op(2'b00); #1;
    chk("add_c1_state", state, st(S_LOAD));
    chk("add_c1_ld", {clr_a, ld_a, ld_m, ld_q}, 4'b0111);
    cyc(); #1;
    chk("add_c2_addsub", {add_en, sub_en}, 2'b10);
    cyc(); #1;
    chk("add_c3_out_lo", out_lo, 1);
    cyc(); #1;
    chk("add_c4_done", {done, error}, 2'b10);
    cyc(); #1;
    chk("add_c5_busy", busy, 0);

    // sub
    begin_op(2'b01); #1;
    cyc(); #1;
    chk("sub_c2_addsub", {add_en, sub_en}, 2'b01);
    cyc(); cyc(); #1;
    chk("sub_c4_done", done, 1);
    cyc();

    // Booth multiply
    begin_op(2'b10);
    n_sh = 0; n_left = 0; done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      j = (c - 2) / 2;
      if (c >= 2) {q0, q_m1} = bpat[j % 4];
      #1;
      if (c >= 2 && c <= 17 && (c % 2) == 0) begin
        chk("mul_chk_state", state, st(S_BOOTH_CHK));
        chk("mul_sub_en", sub_en, bpat[j % 4] == 2'b10);
        chk("mul_add_en", add_en, bpat[j % 4] == 2'b01);
      end
      if (c >= 3 && c <= 17 && (c % 2) == 1) chk("mul_cnt", cnt, j);
      if (shift_en) begin
        n_sh++;
        if (shift_left) n_left++;
      end
      if (done) done_at = c;
      else cyc();
    end
    chk("mul_done_cycle", done_at, 20);
    chk("mul_shifts", n_sh, 8);
    chk("mul_left_shifts", n_left, 0);
    chk("mul_error", error, 0);
    cyc();

    // restoring divide, a_sign 1,0,1,0,...
    begin_op(2'b11);
    n_sh = 0; n_left = 0; done_at = 0;
    for (int c = 1; c <= 50 && done_at == 0; c++) begin
      j  = (c >= 2) ? (c - 2) / 3 : 0;
      ph = (c >= 2) ? (c - 2) % 3 : 3;
      a_sign = ((j % 2) == 0);
      #1;
      if (c <= 25 && ph == 0) chk("div_shift_state", state, st(S_DIV_SHIFT));
      if (c <= 25 && ph == 1) chk("div_sub_en", {add_en, sub_en}, 2'b01);
      if (c <= 25 && ph == 2) begin
        chk("div_fix_state", state, st(S_DIV_FIX));
        chk("div_fix_strobes", {add_en, sub_en, set_q0},
            ((j % 2) == 0) ? 3'b100 : 3'b001);
      end
      if (shift_en) begin
        n_sh++;
        if (shift_left) n_left++;
      end
      if (done) done_at = c;
      else cyc();
    end
    chk("div_done_cycle", done_at, 28);
    chk("div_left_shifts", n_left, 8);
    chk("div_shifts", n_sh, 8);
    chk("div_error", error, 0);
    cyc();
    a_sign = 1'b0;

    // divide by zero
    divisor_zero = 1'b1;
    begin_op(2'b11); #1;
    n_bad = 0;
    chk("dz_c1_state", state, st(S_LOAD));
    chk("dz_c1_clr_a", {clr_a, ld_a}, 2'b10);
    if (add_en || sub_en || shift_en) n_bad++;
    cyc(); #1;
    chk("dz_c2_done_err", {done, error}, 2'b11);
    if (add_en || sub_en || shift_en) n_bad++;
    chk("dz_no_strobes", n_bad, 0);
    divisor_zero = 1'b0;
    cyc(); #1;
    chk("dz_c3_idle", {busy, error}, 2'b00);

    // start held through DONE: one IDLE cycle then a new op
    op = 2'b00; start = 1'b1;
    repeat (4) cyc();
    #1;
    chk("held_c4_done", done, 1);
    cyc(); #1;
    chk("held_c5_idle", state, st(S_IDLE));
    cyc(); #1;
    chk("held_c6_load", state, st(S_LOAD));
    start = 1'b0;
    repeat (3) cyc();
    #1;
    chk("held_c9_done", done, 1);
    cyc();

    // start re-asserted during EXEC is ignored
    begin_op(2'b00);
    cyc();
    op = 2'b11; start = 1'b1; #1;
    chk("exec_start_add", {add_en, sub_en}, 2'b10);
    cyc();
    start = 1'b0; #1;
    chk("exec_start_out_lo", state, st(S_OUT_LO));
    cyc(); #1;
    chk("exec_start_done", done, 1);
    cyc(); #1;
    chk("exec_start_idle", state, st(S_IDLE));

    // reset in BOOTH_SHIFT with cnt=5
    {q0, q_m1} = 2'b00;
    begin_op(2'b10);
    repeat (12) cyc();
    #1;
    chk("mid_pre_state", state, st(S_BOOTH_SHIFT));
    chk("mid_pre_cnt", cnt, 5);
    reset = 1'b1; start = 1'b1;
    cyc(); #1;
    chk("mid_rst_state", state, st(S_IDLE));
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_outs", outs_w, 0);
    reset = 1'b0; start = 1'b0;
    n_bad = 0;
    repeat (25) begin
      cyc(); #1;
      if (done) n_bad++;
    end
    chk("mid_no_done", n_bad, 0);
    chk("mid_idle", state, st(S_IDLE));

    // illegal state vectors recover to IDLE with outputs quiet
    force dut.state_d = 11'b0;
    cyc();
    release dut.state_d; #1;
    chk("ill_zero_state", state, 0);
    chk("ill_zero_outs", outs_w, 0);
    cyc(); #1;
    chk("ill_zero_recover", state, st(S_IDLE));
    force dut.state_d = st(S_IDLE) | st(S_EXEC);
    cyc();
    release dut.state_d; #1;
    chk("ill_multi_state", state, st(S_IDLE) | st(S_EXEC));
    chk("ill_multi_outs", outs_w, 0);
    cyc(); #1;
    chk("ill_multi_recover", state, st(S_IDLE));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
